// File: rtl/r2mdc_pipeline_sequencer.sv
// R2MDC pipeline timing controller: input pair counter, per-stage valid chain, commutator swaps, frame marking.
// Accept-to-output latency NUM_STAGES*BF_LAT + PAIRS-1; in_ready drops only while an aborted frame drains.
module r2mdc_pipeline_sequencer #(
  parameter int NUM_STAGES = 6,
  parameter int PAIRS      = 32,
  parameter int CNTR_W     = 5,
  parameter int BF_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CNTR_W-1:0]     cntr_IFFT_input_pairs,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-2:0] cm_swap,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, ABORT} state_t;

  localparam logic [CNTR_W-1:0] LAST_IDX = CNTR_W'(PAIRS - 1);

  state_t                state_q, state_d;
  logic [CNTR_W-1:0]     cntr_q, cntr_d;
  logic [CNTR_W-1:0]     out_cnt_q, out_cnt_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  pipe_busy;
  logic [NUM_STAGES:0]   en_chain;
  logic [NUM_STAGES-1:0] line_busy;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b1;
    case (state_q)
      IDLE:   if (in_valid) state_d = ACCEPT;
      ACCEPT: if (!in_valid) state_d = (cntr_q != '0) ? ABORT : IDLE;
      ABORT: begin
        in_ready = 1'b0;
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    cntr_d    = cntr_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q | (state_d == ABORT);
    if (state_d == ABORT) cntr_d = '0;
    else if (accept)      cntr_d = cntr_q + CNTR_W'(1);
    // Drained pairs of an aborted frame must never raise out_last.
    if (state_q == ABORT) out_cnt_d = '0;
    else if (out_valid)   out_cnt_d = out_cnt_q + CNTR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cntr_q    <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign en_chain[0] = accept;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    // Stage latency: butterfly register plus commutator delay; the last stage has no commutator.
    localparam int L = (s < NUM_STAGES - 1) ? BF_LAT + (PAIRS >> (s + 1)) : BF_LAT;
    logic [L-1:0] dly_q;
    always_ff @(posedge CLK) begin
      if (!RST_N) dly_q <= '0;
      else        dly_q <= (dly_q << 1) | L'(en_chain[s]);
    end
    assign en_chain[s+1] = dly_q[L-1];
    assign line_busy[s]  = |dly_q;
  end

  for (genvar s = 0; s < NUM_STAGES - 1; s++) begin : g_cm
    logic [CNTR_W-1:0] sc_q;
    always_ff @(posedge CLK) begin
      if (!RST_N || state_q == ABORT) sc_q <= '0;
      else if (en_chain[s])           sc_q <= sc_q + CNTR_W'(1);
    end
    assign cm_swap[s] = sc_q[CNTR_W-1-s];
  end

  assign pipe_busy             = |line_busy;
  assign busy                  = (state_q == ACCEPT) | pipe_busy;
  assign stage_en              = en_chain[NUM_STAGES-1:0];
  assign out_valid             = en_chain[NUM_STAGES];
  assign out_last              = out_valid & (out_cnt_q == LAST_IDX);
  assign frame_done            = out_last;
  assign cntr_IFFT_input_pairs = cntr_q;
  assign err                   = err_q;

endmodule

// File: doc/r2mdc_pipeline_sequencer.md
Name: r2mdc_pipeline_sequencer

Overview:
- Central timing controller for the radix-2 multipath delay commutator (R2MDC) FFT/IFFT pipeline.
- Accepts a contiguous stream of input sample pairs and generates the global pair counter consumed by the pre-delay commutators.
- Generates per-stage valid/enable strobes and per-stage commutator swap selects.
- Marks pipeline output valid/last and frame completion.
- Sits between the input framing logic and the butterfly/commutator stage chain.

Parameters:
- NUM_STAGES, 6, number of butterfly stages (log2 of FFT size).
- PAIRS, 32, sample pairs per frame per path; power of 2, equal to 2^(NUM_STAGES-1).
- CNTR_W, 5, counter width; equals log2(PAIRS).
- BF_LAT, 1, butterfly register latency in cycles, identical for every stage.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_valid  in  1  input pair present this cycle.
- in_ready  out  1  sequencer can accept a pair.
- cntr_IFFT_input_pairs  out  CNTR_W  index of the pair accepted this cycle.
- stage_en  out  NUM_STAGES  bit s high = stage s input valid this cycle.
- cm_swap  out  NUM_STAGES-1  bit s = commutator s swap select (1 = crossed).
- out_valid  out  1  last-stage output pair valid.
- out_last  out  1  final pair of a frame on the output.
- frame_done  out  1  one-cycle pulse coincident with out_last.
- busy  out  1  any pair in flight or a frame partially accepted.
- err  out  1  sticky: frame input gap detected.

Behaviour:
- Reset (RST_N=0 at an edge): all counters and delay lines clear to 0.
  - Outputs after reset: in_ready=1, stage_en=0, cm_swap=0, out_valid=0, out_last=0, frame_done=0, busy=0, err=0, cntr_IFFT_input_pairs=0.
  - A mid-frame reset discards all in-flight data; no out_valid follows.
- FSM states: IDLE, ACCEPT, ABORT.
  - IDLE -> ACCEPT on the first in_valid&in_ready.
  - ACCEPT stays for exactly PAIRS consecutive accepts. After the accept with counter=PAIRS-1, it returns to IDLE, or stays in ACCEPT if in_valid is high the next cycle; back-to-back frames are allowed.
  - ACCEPT -> ABORT if in_valid=0 while 0 < counter < PAIRS.
  - ABORT: err=1, in_ready=0 until the pipeline drains (busy=0), then -> IDLE. err stays set until reset.
- in_ready = 1 in IDLE and ACCEPT, 0 in ABORT.
- Input counter:
  - cntr_IFFT_input_pairs increments on each accept and wraps PAIRS-1 -> 0.
  - The output is registered: it shows the index of the current pair during the accept cycle.
  - It resets to 0 on entering ABORT.
- Stage valid chain:
  - stage_en[0] = in_valid & in_ready (combinational).
  - stage_en[s+1] = stage_en[s] delayed L_s cycles.
  - L_s = BF_LAT + D_s, where D_s = PAIRS >> (s+1) for s < NUM_STAGES-1.
  - The last stage has no commutator, so its latency is BF_LAT.
  - out_valid = last-stage enable delayed BF_LAT.
- End-to-end latency = NUM_STAGES*BF_LAT + (PAIRS-1). Defaults: 37 cycles from accept of pair 0 to out_valid of pair 0.
- Commutator select:
  - A per-stage counter sc[s] (CNTR_W bits) increments on each commutator-input-valid cycle and wraps at PAIRS.
  - cm_swap[s] = bit log2(D_s) of sc[s], registered, so swap toggles every D_s valid pairs.
  - sc[s] clears on reset and on ABORT.
- Output marking:
  - An output counter increments on out_valid.
  - out_last = frame_done = out_valid & (output counter == PAIRS-1).
- busy = ACCEPT state, or any bit set in the delay chains.
- Edge cases:
  - Continuous frames: the last pair of frame N is followed immediately by pair 0 of frame N+1; outputs are contiguous with no bubble.
  - in_valid during ABORT is ignored.

Test Plan:
- Reset then one frame of 32 contiguous pairs -> cntr_IFFT_input_pairs steps 0..31; first out_valid 37 cycles after the first accept; out_valid high 32 cycles; out_last/frame_done on the 32nd output only.
- Two back-to-back frames (64 contiguous in_valid) -> 64 contiguous out_valid cycles with no gap; frame_done pulses exactly twice, 32 cycles apart.
- Stage-0 cm_swap during one frame -> 0 for 16 valid pairs, then 1 for 16. Stage-4 cm_swap toggles every pair.
- in_valid drops after pair 10 -> err=1, in_ready=0; the 10 in-flight pairs drain with no out_last; once busy=0, in_ready=1 and err remains 1.
- RST_N low for 1 cycle at pair 20 -> the next cycle shows every output at its reset value; no out_valid appears over the following 40 cycles.
- in_valid held low after reset -> outputs stay at reset values and busy=0 indefinitely.
